// File: rtl/player_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_lane_ctrl
// Purpose  : Player controller for the lane-crossing game on a VGA field.
//            Moves the player on a grid from synchronised switches, detects
//            collisions against N_LANES car lanes, and runs the lives/score
//            game state machine (PLAY / DYING / GAME_OVER).
// Ports    : CLK, RST        - clock, synchronous active-high reset
//            SW1..SW4        - up/down/left/right switches (asynchronous)
//            car_x           - packed car left-edge x, lane i = [10i+9:10i]
//            player_x/_y     - player top-left corner for the renderer
//            lives, score    - game counters (score saturates at 255)
//            state           - 0=PLAY, 1=DYING, 2=GAME_OVER
//            hit, win        - one-cycle event pulses
//            led             - led[k] = lives > k, all off in GAME_OVER
// Revision : 1.0 - initial release
// ============================================================================
module player_lane_ctrl #(
  parameter int N_LANES     = 4,
  parameter int H_DISPLAY   = 640,
  parameter int V_DISPLAY   = 480,
  parameter int STEP        = 32,
  parameter int PLAYER_W    = 32,
  parameter int PLAYER_H    = 32,
  parameter int CAR_W       = 64,
  parameter int CAR_H       = 32,
  parameter int LANE_Y0     = 64,
  parameter int LANE_PITCH  = 96,
  parameter int START_X     = 320,
  parameter int START_Y     = 448,
  parameter int MOVE_TICKS  = 12500000,
  parameter int DEATH_TICKS = 25000000,
  parameter int LIVES       = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SW1,
  input  logic                 SW2,
  input  logic                 SW3,
  input  logic                 SW4,
  input  logic [N_LANES*10-1:0] car_x,
  output logic [9:0]           player_x,
  output logic [9:0]           player_y,
  output logic [2:0]           lives,
  output logic [7:0]           score,
  output logic [1:0]           state,
  output logic                 hit,
  output logic                 win,
  output logic [3:0]           led
);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_DYING     = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  localparam int c_cd_w = $clog2(MOVE_TICKS + 1);
  localparam int c_dc_w = $clog2(DEATH_TICKS + 1);

  localparam logic [c_cd_w-1:0] c_cd_load = c_cd_w'(MOVE_TICKS - 1);
  localparam logic [c_cd_w-1:0] c_cd_one  = c_cd_w'(1);
  localparam logic [c_dc_w-1:0] c_dc_load = c_dc_w'(DEATH_TICKS - 1);
  localparam logic [c_dc_w-1:0] c_dc_one  = c_dc_w'(1);

  localparam logic [9:0]  c_start_x = 10'(START_X);
  localparam logic [9:0]  c_start_y = 10'(START_Y);
  localparam logic [9:0]  c_step10  = 10'(STEP);
  localparam logic [2:0]  c_lives   = 3'(LIVES);
  // Geometry is compared at 11 bits so sums near the 10-bit limit never wrap.
  localparam logic [10:0] c_step11  = 11'(STEP);
  localparam logic [10:0] c_pw11    = 11'(PLAYER_W);
  localparam logic [10:0] c_ph11    = 11'(PLAYER_H);
  localparam logic [10:0] c_cw11    = 11'(CAR_W);
  localparam logic [10:0] c_ch11    = 11'(CAR_H);
  localparam logic [10:0] c_hdisp11 = 11'(H_DISPLAY);
  localparam logic [10:0] c_vdisp11 = 11'(V_DISPLAY);

  state_t            r_state, w_state_nxt;
  logic [9:0]        r_px, w_px_nxt;
  logic [9:0]        r_py, w_py_nxt;
  logic [2:0]        r_lives, w_lives_nxt;
  logic [7:0]        r_score, w_score_nxt;
  logic [c_cd_w-1:0] r_cd, w_cd_nxt;
  logic [c_dc_w-1:0] r_dc, w_dc_nxt;
  logic              r_hit, w_hit_nxt;
  logic              r_win, w_win_nxt;
  // Bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right.
  logic [3:0]        r_sw_meta, r_sw_sync, r_sw_prev;

  logic [3:0]         w_s, w_rise;
  logic [10:0]        w_px11, w_py11;
  logic [N_LANES-1:0] w_hit_lane;
  logic               w_hit_any;

  assign w_s    = r_sw_sync;
  assign w_rise = r_sw_sync & ~r_sw_prev;
  assign w_px11 = {1'b0, r_px};
  assign w_py11 = {1'b0, r_py};

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    localparam logic [10:0] c_cy = 11'(LANE_Y0 + i * LANE_PITCH);
    logic [10:0] w_cx;
    assign w_cx = {1'b0, car_x[10*i +: 10]};
    assign w_hit_lane[i] = (w_px11 + c_pw11 > w_cx) && (w_px11 < w_cx + c_cw11) &&
                           (w_py11 + c_ph11 > c_cy) && (w_py11 < c_cy + c_ch11);
  end

  assign w_hit_any = |w_hit_lane;

  always_comb begin
    w_state_nxt = r_state;
    w_px_nxt    = r_px;
    w_py_nxt    = r_py;
    w_lives_nxt = r_lives;
    w_score_nxt = r_score;
    w_cd_nxt    = r_cd;
    w_dc_nxt    = r_dc;
    w_hit_nxt   = 1'b0;
    w_win_nxt   = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (w_hit_any) begin
          w_hit_nxt = 1'b1;
          w_px_nxt  = c_start_x;
          w_py_nxt  = c_start_y;
          if (r_lives > 3'd1) begin
            w_lives_nxt = r_lives - 3'd1;
            w_state_nxt = ST_DYING;
            w_dc_nxt    = c_dc_load;
          end else begin
            w_lives_nxt = 3'd0;
            w_state_nxt = ST_GAME_OVER;
          end
        end else if (r_py == 10'd0) begin
          w_win_nxt = 1'b1;
          if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
          w_px_nxt = c_start_x;
          w_py_nxt = c_start_y;
          w_cd_nxt = c_cd_load;
        end else if (r_cd != '0) begin
          w_cd_nxt = r_cd - c_cd_one;
        end else begin
          // A blocked direction falls through to the next candidate.
          if (w_s[0] && (w_py11 >= c_step11)) begin
            w_py_nxt = r_py - c_step10;
            w_cd_nxt = c_cd_load;
          end else if (w_s[1] && (w_py11 + c_ph11 + c_step11 <= c_vdisp11)) begin
            w_py_nxt = r_py + c_step10;
            w_cd_nxt = c_cd_load;
          end else if (w_s[2] && (w_px11 >= c_step11)) begin
            w_px_nxt = r_px - c_step10;
            w_cd_nxt = c_cd_load;
          end else if (w_s[3] && (w_px11 + c_pw11 + c_step11 <= c_hdisp11)) begin
            w_px_nxt = r_px + c_step10;
            w_cd_nxt = c_cd_load;
          end
        end
      end
      ST_DYING: begin
        if (r_dc == '0) begin
          w_state_nxt = ST_PLAY;
          w_cd_nxt    = '0;
        end else begin
          w_dc_nxt = r_dc - c_dc_one;
        end
      end
      ST_GAME_OVER: begin
        w_px_nxt = c_start_x;
        w_py_nxt = c_start_y;
        // Only a fresh press restarts; a switch held on entry has no edge.
        if (|w_rise) begin
          w_lives_nxt = c_lives;
          w_score_nxt = 8'd0;
          w_cd_nxt    = c_cd_load;
          w_state_nxt = ST_PLAY;
        end
      end
      default: w_state_nxt = ST_PLAY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_PLAY;
      r_px      <= c_start_x;
      r_py      <= c_start_y;
      r_lives   <= c_lives;
      r_score   <= 8'd0;
      r_cd      <= '0;
      r_dc      <= '0;
      r_hit     <= 1'b0;
      r_win     <= 1'b0;
      r_sw_meta <= 4'd0;
      r_sw_sync <= 4'd0;
      r_sw_prev <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_px      <= w_px_nxt;
      r_py      <= w_py_nxt;
      r_lives   <= w_lives_nxt;
      r_score   <= w_score_nxt;
      r_cd      <= w_cd_nxt;
      r_dc      <= w_dc_nxt;
      r_hit     <= w_hit_nxt;
      r_win     <= w_win_nxt;
      r_sw_meta <= {SW4, SW3, SW2, SW1};
      r_sw_sync <= r_sw_meta;
      r_sw_prev <= r_sw_sync;
    end
  end

  assign player_x = r_px;
  assign player_y = r_py;
  assign lives    = r_lives;
  assign score    = r_score;
  assign state    = r_state;
  assign hit      = r_hit;
  assign win      = r_win;
  assign led      = (r_state == ST_GAME_OVER) ? 4'd0 :
                    {(r_lives > 3'd3), (r_lives > 3'd2), (r_lives > 3'd1), (r_lives > 3'd0)};

endmodule
`default_nettype wire

// File: tb/tb_player_lane_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_lane_ctrl
// Purpose  : Self-checking bench for player_lane_ctrl. A behavioural game
//            model (plain integers) is stepped every clock and compared with
//            all DUT outputs; directed scenarios add fixed-value checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_lane_ctrl;

  localparam int N_LANES    = 4;
  localparam int MT         = 4;
  localparam int DT         = 8;
  localparam int STEP       = 32;
  localparam int PW         = 32;
  localparam int PH         = 32;
  localparam int CW         = 64;
  localparam int CH         = 32;
  localparam int LANE_Y0    = 64;
  localparam int LANE_PITCH = 96;
  localparam int HD         = 640;
  localparam int VD         = 480;
  localparam int SX         = 320;
  localparam int SY         = 448;
  localparam int NLIVES     = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [3:0]            sw;
  logic [N_LANES*10-1:0] car_x;
  logic [9:0]            player_x, player_y;
  logic [2:0]            lives;
  logic [7:0]            score;
  logic [1:0]            state;
  logic                  hit, win;
  logic [3:0]            led;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_px, m_py, m_lives, m_score, m_st, m_cd, m_dc;
  bit m_hit, m_win;
  bit [3:0] m_q1, m_q2, m_q3;

  always #5 clk = ~clk;

  player_lane_ctrl #(
    .N_LANES(N_LANES), .MOVE_TICKS(MT), .DEATH_TICKS(DT), .LIVES(NLIVES)
  ) dut (
    .CLK(clk), .RST(rst),
    .SW1(sw[0]), .SW2(sw[1]), .SW3(sw[2]), .SW4(sw[3]),
    .car_x(car_x),
    .player_x(player_x), .player_y(player_y),
    .lives(lives), .score(score), .state(state),
    .hit(hit), .win(win), .led(led)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_led();
    int v = 0;
    if (m_st != 2)
      for (int k = 0; k < 4; k++) if (m_lives > k) v |= (1 << k);
    return v;
  endfunction

  task automatic model_step();
    bit [3:0] s, rise;
    bit coll;
    if (rst) begin
      m_px = SX; m_py = SY; m_lives = NLIVES; m_score = 0; m_st = 0;
      m_cd = 0; m_dc = 0; m_hit = 0; m_win = 0;
      m_q1 = 0; m_q2 = 0; m_q3 = 0;
      return;
    end
    s    = m_q2;
    rise = m_q2 & ~m_q3;
    m_hit = 0;
    m_win = 0;
    if (m_st == 0) begin
      coll = 0;
      for (int i = 0; i < N_LANES; i++) begin
        int cx;
        int cy;
        cx = int'(car_x[10*i +: 10]);
        cy = LANE_Y0 + i * LANE_PITCH;
        if (m_px + PW > cx && m_px < cx + CW && m_py + PH > cy && m_py < cy + CH) coll = 1;
      end
      if (coll) begin
        m_hit = 1; m_px = SX; m_py = SY;
        if (m_lives > 1) begin m_lives--; m_st = 1; m_dc = DT - 1; end
        else begin m_lives = 0; m_st = 2; end
      end else if (m_py == 0) begin
        m_win = 1;
        if (m_score < 255) m_score++;
        m_px = SX; m_py = SY; m_cd = MT - 1;
      end else if (m_cd != 0) begin
        m_cd--;
      end else begin
        if (s[0] && m_py >= STEP) begin m_py -= STEP; m_cd = MT - 1; end
        else if (s[1] && m_py + PH + STEP <= VD) begin m_py += STEP; m_cd = MT - 1; end
        else if (s[2] && m_px >= STEP) begin m_px -= STEP; m_cd = MT - 1; end
        else if (s[3] && m_px + PW + STEP <= HD) begin m_px += STEP; m_cd = MT - 1; end
      end
    end else if (m_st == 1) begin
      if (m_dc == 0) begin m_st = 0; m_cd = 0; end
      else m_dc--;
    end else begin
      m_px = SX; m_py = SY;
      if (rise != 0) begin m_lives = NLIVES; m_score = 0; m_cd = MT - 1; m_st = 0; end
    end
    m_q3 = m_q2; m_q2 = m_q1; m_q1 = sw;
  endtask

  task automatic check_all();
    check_eq("player_x", 32'(player_x), m_px);
    check_eq("player_y", 32'(player_y), m_py);
    check_eq("lives",    32'(lives),    m_lives);
    check_eq("score",    32'(score),    m_score);
    check_eq("state",    32'(state),    m_st);
    check_eq("hit",      32'(hit),      32'(m_hit));
    check_eq("win",      32'(win),      32'(m_win));
    check_eq("led",      32'(led),      model_led());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sw = 4'd0;
    car_x = {N_LANES{10'd1000}};
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int wins_at_max;
    rst = 1'b1;
    sw = 4'd0;
    car_x = {N_LANES{10'd1000}};

    // Reset state
    do_reset();
    check_eq("rst_x", 32'(player_x), SX);
    check_eq("rst_y", 32'(player_y), SY);
    check_eq("rst_lives", 32'(lives), 3);
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_led", 32'(led), 4'b0111);

    // Held up switch: first hop 3 cycles after press, then every MT cycles
    sw = 4'b0001;
    tick(); tick();
    check_eq("lat_before", 32'(player_y), 448);
    tick();
    check_eq("lat_first", 32'(player_y), 416);
    repeat (4) tick();
    check_eq("hop_second", 32'(player_y), 384);
    repeat (13) tick();
    check_eq("hold20_y", 32'(player_y), 288);
    check_eq("hold20_x", 32'(player_x), 320);

    // Blocked directions at (0,448), then right is accepted
    do_reset();
    sw = 4'b0100;
    repeat (45) tick();
    check_eq("left_edge_x", 32'(player_x), 0);
    sw = 4'b0110;
    repeat (10) tick();
    check_eq("blocked_x", 32'(player_x), 0);
    check_eq("blocked_y", 32'(player_y), 448);
    sw = 4'b1110;
    tick(); tick();
    check_eq("right_sync_x", 32'(player_x), 0);
    tick();
    check_eq("right_move_x", 32'(player_x), 32);

    // Collision in lane 0, DYING ignores switches
    do_reset();
    car_x[9:0] = 10'd300;
    sw = 4'b0001;
    n = 0;
    while (!m_hit && n < 200) begin tick(); n++; end
    check_eq("hit_timeout", 32'(m_hit), 1);
    check_eq("hit_pulse", 32'(hit), 1);
    check_eq("hit_pos_y", 32'(player_y), 448);
    check_eq("hit_lives", 32'(lives), 2);
    check_eq("hit_state", 32'(state), 1);
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq("dying_state", 32'(state), 1);
      check_eq("dying_y", 32'(player_y), 448);
    end
    tick();
    check_eq("dying_done", 32'(state), 0);
    tick();
    check_eq("post_dying_hop", 32'(player_y), 416);

    // Run into the car until game over, then restart on a fresh press
    n = 0;
    while (m_st != 2 && n < 500) begin tick(); n++; end
    check_eq("gameover_timeout", 32'(m_st), 2);
    check_eq("gameover_state", 32'(state), 2);
    check_eq("gameover_led", 32'(led), 0);
    check_eq("gameover_lives", 32'(lives), 0);
    repeat (10) tick();
    check_eq("held_no_restart", 32'(state), 2);
    sw = 4'b0000;
    repeat (4) tick();
    sw = 4'b0001;
    tick(); tick();
    check_eq("restart_wait", 32'(state), 2);
    tick();
    check_eq("restart_state", 32'(state), 0);
    check_eq("restart_lives", 32'(lives), 3);
    check_eq("restart_score", 32'(score), 0);

    // Crossing and score saturation
    do_reset();
    sw = 4'b0001;
    n = 0;
    while (!m_win && n < 200) begin tick(); n++; end
    check_eq("win_timeout", 32'(m_win), 1);
    check_eq("win_pulse", 32'(win), 1);
    check_eq("win_score", 32'(score), 1);
    check_eq("win_x", 32'(player_x), 320);
    check_eq("win_y", 32'(player_y), 448);
    wins_at_max = 0;
    for (int k = 0; k < 20000 && wins_at_max < 2; k++) begin
      tick();
      if (m_win && m_score == 255) wins_at_max++;
    end
    check_eq("sat_timeout", wins_at_max, 2);
    check_eq("score_sat", 32'(score), 255);

    // Randomised play against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        int lane;
        lane = int'($urandom_range(0, N_LANES - 1));
        car_x[10*lane +: 10] = 10'($urandom_range(0, 1023));
      end
      tick();
    end

    // Reset while dying with death counter at 5
    do_reset();
    car_x[9:0] = 10'd300;
    sw = 4'b0001;
    n = 0;
    while (!(m_st == 1 && m_dc == 5) && n < 300) begin tick(); n++; end
    check_eq("dying5_timeout", m_dc, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstdie_state", 32'(state), 0);
    check_eq("rstdie_lives", 32'(lives), 3);
    check_eq("rstdie_score", 32'(score), 0);
    check_eq("rstdie_x", 32'(player_x), 320);
    check_eq("rstdie_y", 32'(player_y), 448);
    check_eq("rstdie_hit", 32'(hit), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
